// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side signal bundle for hazard_stall_unit.
// The master modport is the pipeline/decoder; the slave modport is the hazard unit.
interface hazard_stall_unit_if;
  logic       reg_wr_DE;
  logic       wb_sel_DE;
  logic [6:0] instr_opcode_DE;
  logic [4:0] rd_DE;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       dmem_ready;
  logic       br_taken;
  logic       stall_IF;
  logic       Control_stall;
  logic       flush_DE;
  logic       fwd_a;
  logic       fwd_b;
  logic       mem_err;

  modport master (
    output reg_wr_DE, wb_sel_DE, instr_opcode_DE, rd_DE, rs1, rs2, dmem_ready, br_taken,
    input  stall_IF, Control_stall, flush_DE, fwd_a, fwd_b, mem_err
  );

  modport slave (
    input  reg_wr_DE, wb_sel_DE, instr_opcode_DE, rd_DE, rs1, rs2, dmem_ready, br_taken,
    output stall_IF, Control_stall, flush_DE, fwd_a, fwd_b, mem_err
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush/forward control for the DE stage with a data-memory timeout trap.
// Optional macro HAZARD_PERF_CNT_EN adds a 32-bit stall_cnt output counting stall_IF cycles.
module hazard_stall_unit (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_unit_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {RUN, MEM_WAIT, LOAD_USE, ERR} state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       mem_op;
  logic       load_use;
  logic       stall_if_d;
  logic       ctrl_stall_d;
  logic       flush_d;
  logic       mem_err_d;

  assign mem_op   = (hz.instr_opcode_DE == OP_LOAD) || (hz.instr_opcode_DE == OP_STORE);
  assign load_use = hz.wb_sel_DE && hz.reg_wr_DE && (hz.rd_DE != 5'd0) &&
                    ((hz.rs1 == hz.rd_DE) || (hz.rs2 == hz.rd_DE));

  assign hz.fwd_a = hz.reg_wr_DE && !hz.wb_sel_DE && (hz.rd_DE != 5'd0) && (hz.rs1 == hz.rd_DE);
  assign hz.fwd_b = hz.reg_wr_DE && !hz.wb_sel_DE && (hz.rd_DE != 5'd0) && (hz.rs2 == hz.rd_DE);

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    wait_cnt_q <= wait_cnt_d;
  end

  // Priority inside each state: memory stall, then branch flush, then load-use bubble.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    stall_if_d   = 1'b0;
    ctrl_stall_d = 1'b0;
    flush_d      = 1'b0;
    mem_err_d    = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_op && !hz.dmem_ready) begin
          stall_if_d   = 1'b1;
          ctrl_stall_d = 1'b1;
          wait_cnt_d   = 4'd0;
          state_d      = MEM_WAIT;
        end else if (hz.br_taken) begin
          flush_d = 1'b1;
        end else if (load_use) begin
          stall_if_d = 1'b1;
          flush_d    = 1'b1;
          state_d    = LOAD_USE;
        end
      end
      MEM_WAIT: begin
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (hz.dmem_ready) begin
          flush_d = hz.br_taken;
          state_d = RUN;
        end else begin
          stall_if_d   = 1'b1;
          ctrl_stall_d = 1'b1;
          if (wait_cnt_q == 4'd15) begin
            state_d = ERR;
          end
        end
      end
      LOAD_USE: begin
        flush_d = hz.br_taken;
        state_d = RUN;
      end
      ERR: begin
        stall_if_d   = 1'b1;
        ctrl_stall_d = 1'b1;
        mem_err_d    = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Reset holds a bubble in DE and masks every stall while it is asserted.
    if (rst) begin
      state_d      = RUN;
      wait_cnt_d   = 4'd0;
      stall_if_d   = 1'b0;
      ctrl_stall_d = 1'b0;
      flush_d      = 1'b1;
      mem_err_d    = 1'b0;
    end
  end

  assign hz.stall_IF      = stall_if_d;
  assign hz.Control_stall = ctrl_stall_d;
  assign hz.flush_DE      = flush_d;
  assign hz.mem_err       = mem_err_d;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = rst        ? 32'd0 :
                       stall_if_d ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
